// File: rtl/stdp_synapse_array.sv
// stdp_synapse_array
//   Array of N_CH plastic synapses feeding one neuron, with
//   pair-based STDP learning driven by exponentially decaying traces.
//
//   Each presynaptic channel k keeps a trace that jumps by TRACE_INC on a
//   spike and decays geometrically by trace >> DECAY_SHIFT every cycle.
//   The decay falls back to -1 once the shift term reaches zero, so every
//   trace eventually returns to 0.
//   - Potentiation: a post spike strengthens every channel whose trace is
//     still nonzero.
//   - Depression: a pre spike while the post trace is nonzero weakens that
//     channel.
//   Weights saturate at 0 and W_MAX.
//
//   Optional feature (macro STDP_DEPRESSION_EN):
//     defined   - the post trace exists and depression is active.
//     undefined - potentiation only, and there is no post trace register.
//
//   There is no valid/ready handshake. Spikes are single-cycle pulses
//   sampled on every rising edge, and outputs are always valid.
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   learn_en    in   1 = weight updates enabled
//   pre_spike   in   [N_CH]   presynaptic spike pulses, bit k = channel k
//   post_spike  in   postsynaptic spike pulse
//   weight_sel  in   [SEL_W]  readback channel index
//   i_syn       out  [WIDTH]  registered, clamped sum of spiking weights
//   weight_rd   out  [WIDTH]  combinational weight[weight_sel]; 0 if out of range

module stdp_synapse_array #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 8,
    parameter int TRACE_W     = 8,
    parameter int TRACE_INC   = 8,
    parameter int DECAY_SHIFT = 2,
    parameter int W_INIT      = 16,
    parameter int W_MAX       = (1 << WIDTH) - 1,
    parameter int A_PLUS      = 1,
    parameter int A_MINUS     = 1,
    localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             learn_en,
    input  logic [N_CH-1:0]  pre_spike,
    input  logic             post_spike,
    input  logic [SEL_W-1:0] weight_sel,
    output logic [WIDTH-1:0] i_syn,
    output logic [WIDTH-1:0] weight_rd
);

    localparam int SUM_W = WIDTH + $clog2(N_CH);
    localparam int WX    = WIDTH + 2;

    localparam logic [WX-1:0]      W_MAX_X     = WX'(W_MAX);
    localparam logic [WX-1:0]      A_PLUS_X    = WX'(A_PLUS);
    localparam logic [WX-1:0]      A_MINUS_X   = WX'(A_MINUS);
    localparam logic [WIDTH-1:0]   W_INIT_V    = WIDTH'(W_INIT);
    localparam logic [TRACE_W:0]   TRACE_INC_X = (TRACE_W + 1)'(TRACE_INC);
    localparam logic [TRACE_W:0]   TRACE_MAX_X = {1'b0, {TRACE_W{1'b1}}};
    localparam logic [SUM_W-1:0]   I_MAX       = SUM_W'({WIDTH{1'b1}});

    logic [TRACE_W-1:0] pre_trace     [N_CH];
    logic [TRACE_W-1:0] pre_trace_nxt [N_CH];
    logic [WIDTH-1:0]   weight        [N_CH];
    logic [WIDTH-1:0]   weight_nxt    [N_CH];
    logic [SUM_W-1:0]   acc;
    logic [WIDTH-1:0]   i_syn_nxt;
    logic               post_active;

    // The decay and the spike bump happen together. The increment is added
    // to the already-decayed value, then clamped to the trace range.
    function automatic logic [TRACE_W-1:0] trace_next(input logic [TRACE_W-1:0] t,
                                                      input logic spike);
        logic [TRACE_W-1:0] dec;
        logic [TRACE_W-1:0] decayed;
        logic [TRACE_W:0]   bumped;
        dec = t >> DECAY_SHIFT;
        if (dec == '0 && t != '0) begin
            decayed = t - TRACE_W'(1);
        end else begin
            decayed = t - dec;
        end
        bumped = {1'b0, decayed} + TRACE_INC_X;
        if (!spike) begin
            return decayed;
        end else if (bumped > TRACE_MAX_X) begin
            return '1;
        end else begin
            return bumped[TRACE_W-1:0];
        end
    endfunction

    // Potentiation and depression are folded into one net change. The
    // result is clamped to [0, W_MAX] in a two-bit-wider domain, so it
    // never wraps.
    function automatic logic [WIDTH-1:0] weight_next(input logic [WIDTH-1:0] w,
                                                     input logic pot,
                                                     input logic dep);
        logic [WX-1:0] up;
        logic [WX-1:0] dn;
        up = {2'b00, w} + (pot ? A_PLUS_X : '0);
        dn = dep ? A_MINUS_X : '0;
        if (up <= dn) begin
            return '0;
        end
        up = up - dn;
        if (up > W_MAX_X) begin
            return W_MAX_X[WIDTH-1:0];
        end
        return up[WIDTH-1:0];
    endfunction

`ifdef STDP_DEPRESSION_EN
    logic [TRACE_W-1:0] post_trace;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            post_trace <= '0;
        end else begin
            post_trace <= trace_next(post_trace, post_spike);
        end
    end

    assign post_active = (post_trace != '0);
`else
    assign post_active = 1'b0;
`endif

    // All decisions read the pre-edge registers. A spike on this edge
    // cannot satisfy its own trace test.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            pre_trace_nxt[k] = trace_next(pre_trace[k], pre_spike[k]);
            weight_nxt[k]    = weight_next(weight[k],
                                           learn_en && post_spike && (pre_trace[k] != '0),
                                           learn_en && pre_spike[k] && post_active);
        end
    end

    // The current is summed from the pre-update weights.
    always_comb begin
        acc = '0;
        for (int k = 0; k < N_CH; k++) begin
            acc = acc + (pre_spike[k] ? SUM_W'(weight[k]) : '0);
        end
        i_syn_nxt = (acc > I_MAX) ? '1 : acc[WIDTH-1:0];
    end

    always_comb begin
        weight_rd = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(weight_sel) == k) begin
                weight_rd = weight[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_CH; k++) begin
                pre_trace[k] <= '0;
                weight[k]    <= W_INIT_V;
            end
            i_syn <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                pre_trace[k] <= pre_trace_nxt[k];
                weight[k]    <= weight_nxt[k];
            end
            i_syn <= i_syn_nxt;
        end
    end

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Bench for stdp_synapse_array.
//   Five instances share one stimulus stream:
//     u_main - default parameters
//     u_w200 - W_INIT = 200
//     u_w255 - W_INIT = 255
//     u_w0   - W_INIT = 0
//     u_n3   - N_CH = 3, so weight_sel can be out of range
//   The driver pushes each expected value into exp_q and raises chk_valid
//   for one cycle. The monitor pops and compares on the falling edge.

module tb_stdp_synapse_array;

    localparam int K_MAIN_I = 0;
    localparam int K_MAIN_W = 1;
    localparam int K_W200_I = 2;
    localparam int K_W255_W = 3;
    localparam int K_W0_W   = 4;
    localparam int K_N3_W   = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       learn_en = 1'b0;
    logic [3:0] pre_spike = '0;
    logic       post_spike = 1'b0;
    logic [1:0] weight_sel = '0;
    logic       chk_valid = 1'b0;

    logic [7:0] i_main, w_main, i_w200, w_w200, i_w255, w_w255, i_w0, w_w0, i_n3, w_n3;

    logic [7:0] exp_q[$];
    int         kind_q[$];
    string      name_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_dep;

    // Clock and DUTs
    always #5 clk = ~clk;

    stdp_synapse_array u_main (
        .clk(clk), .reset_n(reset_n), .learn_en(learn_en), .pre_spike(pre_spike),
        .post_spike(post_spike), .weight_sel(weight_sel), .i_syn(i_main), .weight_rd(w_main));
    stdp_synapse_array #(.W_INIT(200)) u_w200 (
        .clk(clk), .reset_n(reset_n), .learn_en(learn_en), .pre_spike(pre_spike),
        .post_spike(post_spike), .weight_sel(weight_sel), .i_syn(i_w200), .weight_rd(w_w200));
    stdp_synapse_array #(.W_INIT(255)) u_w255 (
        .clk(clk), .reset_n(reset_n), .learn_en(learn_en), .pre_spike(pre_spike),
        .post_spike(post_spike), .weight_sel(weight_sel), .i_syn(i_w255), .weight_rd(w_w255));
    stdp_synapse_array #(.W_INIT(0)) u_w0 (
        .clk(clk), .reset_n(reset_n), .learn_en(learn_en), .pre_spike(pre_spike),
        .post_spike(post_spike), .weight_sel(weight_sel), .i_syn(i_w0), .weight_rd(w_w0));
    stdp_synapse_array #(.N_CH(3)) u_n3 (
        .clk(clk), .reset_n(reset_n), .learn_en(learn_en), .pre_spike(pre_spike[2:0]),
        .post_spike(post_spike), .weight_sel(weight_sel), .i_syn(i_n3), .weight_rd(w_n3));

    // Monitor / scoreboard
    logic [7:0] m_exp;
    logic [7:0] m_act;
    int         m_kind;
    string      m_name;

    always @(negedge clk) begin
        if (chk_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                m_exp  = exp_q.pop_front();
                m_kind = kind_q.pop_front();
                m_name = name_q.pop_front();
                case (m_kind)
                    K_MAIN_I: m_act = i_main;
                    K_MAIN_W: m_act = w_main;
                    K_W200_I: m_act = i_w200;
                    K_W255_W: m_act = w_w255;
                    K_W0_W:   m_act = w_w0;
                    default:  m_act = w_n3;
                endcase
                if (m_act !== m_exp) begin
                    failures++;
                    $display("FAIL %s actual=%0d required=%0d", m_name, m_act, m_exp);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int kind, input logic [1:0] sel, input logic [7:0] exp,
                         input string name);
        weight_sel = sel;
        exp_q.push_back(exp);
        kind_q.push_back(kind);
        name_q.push_back(name);
        chk_valid = 1'b1;
        tick();
        chk_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        learn_en   = 1'b0;
        pre_spike  = '0;
        post_spike = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Pre spike on ch0, then post on the next edge, then long enough idle for
    // every trace to drain to zero.
    task automatic pre_post_pair();
        pre_spike = 4'b0001;
        tick();
        pre_spike  = '0;
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
`ifdef STDP_DEPRESSION_EN
        exp_dep = 8'd15;
`else
        exp_dep = 8'd16;
`endif
        // Reset state and readback
        tick();
        do_reset();
        check(K_MAIN_W, 2'd0, 8'd16, "reset_w0");
        check(K_MAIN_W, 2'd1, 8'd16, "reset_w1");
        check(K_MAIN_W, 2'd2, 8'd16, "reset_w2");
        check(K_MAIN_W, 2'd3, 8'd16, "reset_w3");
        check(K_MAIN_I, 2'd0, 8'd0,  "reset_i_syn");
        check(K_N3_W,   2'd2, 8'd16, "n3_w2");
        check(K_N3_W,   2'd3, 8'd0,  "n3_sel_out_of_range");

        // Pre then post potentiates ch0 only
        learn_en  = 1'b1;
        pre_spike = 4'b0001;
        tick();
        pre_spike  = '0;
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        learn_en   = 1'b0;
        check(K_MAIN_W, 2'd0, 8'd17, "pot_w0");
        check(K_MAIN_W, 2'd1, 8'd16, "pot_w1");
        check(K_MAIN_W, 2'd2, 8'd16, "pot_w2");
        check(K_MAIN_W, 2'd3, 8'd16, "pot_w3");
        check(K_W255_W, 2'd0, 8'd255, "pot_sat_w255");

        // Same-cycle pre+post on a fresh channel: no change
        do_reset();
        learn_en   = 1'b1;
        pre_spike  = 4'b0010;
        post_spike = 1'b1;
        tick();
        pre_spike  = '0;
        post_spike = 1'b0;
        learn_en   = 1'b0;
        check(K_MAIN_W, 2'd1, 8'd16, "same_cycle_w1");
        check(K_MAIN_W, 2'd0, 8'd16, "same_cycle_w0");

        // Repeated pairs, then asynchronous reset mid-cycle
        do_reset();
        learn_en = 1'b1;
        pre_post_pair();
        pre_post_pair();
        check(K_MAIN_W, 2'd0, 8'd18, "two_pairs_w0");
        learn_en = 1'b0;
        reset_n  = 1'b0;
        check(K_MAIN_W, 2'd0, 8'd16, "async_reset_w0");
        check(K_W255_W, 2'd0, 8'd255, "async_reset_w255");
        check(K_MAIN_W, 2'd1, 8'd16, "async_reset_w1");
        reset_n = 1'b1;

        // Summed current, latency and clamp
        do_reset();
        pre_spike = 4'b0011;
        tick();
        pre_spike = '0;
        check(K_MAIN_I, 2'd0, 8'd32, "i_syn_0011");
        check(K_MAIN_I, 2'd0, 8'd0,  "i_syn_cleared");
        pre_spike = 4'b1111;
        tick();
        pre_spike = '0;
        check(K_W200_I, 2'd0, 8'd255, "i_syn_clamp_w200");
        pre_spike = 4'b1111;
        tick();
        pre_spike = '0;
        check(K_MAIN_I, 2'd0, 8'd64, "i_syn_1111");

        // Trace lifetime: the ch0 trace is 1 six edges after the spike,
        // then 0 one edge later.
        do_reset();
        learn_en  = 1'b1;
        pre_spike = 4'b0001;
        tick();
        pre_spike = '0;
        repeat (6) tick();
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        learn_en   = 1'b0;
        check(K_MAIN_W, 2'd0, 8'd17, "trace_last_nonzero");
        do_reset();
        learn_en  = 1'b1;
        pre_spike = 4'b0001;
        tick();
        pre_spike = '0;
        repeat (7) tick();
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        learn_en   = 1'b0;
        check(K_MAIN_W, 2'd0, 8'd16, "trace_expired");

        // learn_en low freezes weights
        do_reset();
        pre_spike = 4'b0001;
        tick();
        pre_spike  = '0;
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        check(K_MAIN_W, 2'd0, 8'd16, "learn_off_w0");

        // Post then pre: depression, if built in
        do_reset();
        learn_en   = 1'b1;
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        pre_spike  = 4'b0100;
        tick();
        pre_spike = '0;
        learn_en  = 1'b0;
        check(K_MAIN_W, 2'd2, exp_dep, "dep_w2");
        check(K_W0_W,   2'd2, 8'd0,    "dep_floor_w0");

        // Final report
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
